hex2binary_stream: RTL
======================

// Module: hex2binary_stream
// PURPOSE
//   Serial ASCII-hex-to-binary parser. Accepts one ASCII character per cycle over a
//   valid/ready stream, MSB digit first, and accumulates N/4 hex digits into an
//   N-bit binary word. The word is presented on a valid/ready output. Used on
//   text-command paths such as the UART console and the test loader.
// PARAMETERS
//   N       32      output word width in bits; must be a multiple of 4 and >= 8
//   DIGITS  N/4     digits per word; derived localparam, not overridable
// PORTS
//   clk         in   1    clock; all logic is rising-edge
//   rst         in   1    synchronous, active-high reset
//   char_in     in   8    ASCII character
//   char_valid  in   1    char_in is valid this cycle
//   char_ready  out  1    parser accepts char_in this cycle
//   bin_num     out  N    parsed word; the first digit lands in bin_num[N-1:N-4]
//   bin_valid   out  1    bin_num holds a complete word
//   bin_ready   in   1    downstream consumes bin_num
//   err         out  1    one-cycle pulse: a non-hex character was accepted
// BEHAVIOUR
//   - Reset values: state=COLLECT, digit count=0, accumulator=0, bin_num=0,
//     bin_valid=0, err=0. char_ready is 0 in any cycle where rst=1.
//   - Handshakes: a character is accepted when char_valid && char_ready.
//     A word is consumed when bin_valid && bin_ready.
//   - Hex decode: '0'-'9' map to 0-9. 'A'-'F' and 'a'-'f' map to 10-15.
//     Every other code, including space, CR and LF, is invalid.
//   - State COLLECT: char_ready=1 and bin_valid=0.
//     - Valid digit: acc <= {acc[N-5:0], nibble}; cnt <= cnt+1.
//     - Valid digit when cnt==DIGITS-1: bin_num <= {acc[N-5:0], nibble};
//       bin_valid <= 1; cnt <= 0; acc <= 0; go to OUTPUT.
//     - Invalid char: err <= 1 for exactly one cycle. acc and cnt are cleared,
//       the partial word is discarded, and the state stays COLLECT (resync).
//     - No accepted char: hold all state.
//   - State OUTPUT: char_ready=0. Characters offered here are not consumed.
//     bin_num and bin_valid are held stable until consumed. On consume:
//     bin_valid <= 0 and go to COLLECT. bin_num keeps its last value.
//   - Latency: bin_valid rises on the clock edge that accepts the final digit,
//     i.e. it is visible the cycle after that digit is presented.
//     Peak throughput is one word per DIGITS+1 cycles.
//   - err is registered and fires only in COLLECT. It never coincides with
//     bin_valid rising.
//   - Reset mid-word or mid-OUTPUT: the partial or pending word is dropped and all
//     reset values apply on the next cycle.
//   - cnt is ceil(log2(DIGITS)) bits wide. It never exceeds DIGITS-1 and never wraps.
// TESTING
//   1. Send "00000000" with char_valid held 1 and bin_ready=1 -> bin_valid is high
//      for 1 cycle with bin_num=32'h00000000, err stays 0.
//   2. Send "FFFFFFFF", then "ffffffff" -> two words, both 32'hFFFFFFFF.
//   3. Send "AAAAAAAA", then "CAF01357" -> 32'hAAAAAAAA, then 32'hCAF01357.
//      Also insert random char_valid gaps -> same results, no extra words.
//   4. Send "12G" then "12345678" -> one err pulse after 'G', then a single word
//      32'h12345678. The "12" prefix must not appear in any word.
//   5. Complete "DEADBEEF" with bin_ready=0 for 5 cycles while char_valid=1
//      -> bin_num=32'hDEADBEEF is held stable, char_ready=0, nothing is consumed.
//      Raise bin_ready -> the word is consumed and the next characters are parsed.
//   6. Assert rst for 1 cycle after "1234" -> bin_valid=0, err=0, bin_num=0.
//      Then send "89ABCDEF" -> 32'h89ABCDEF.

Source files
------------

// File: rtl/hex2binary_stream.sv
// -----------------------------------------------------------------------------
// hex2binary_stream
//   Serial ASCII-hex to binary word parser. One ASCII character is accepted per
//   cycle over a valid/ready stream, most significant digit first. After N/4
//   valid hex digits the assembled N-bit word is presented on a valid/ready
//   output and held until the consumer takes it. A non-hex character discards
//   the partial word and raises a one-cycle err pulse so the parser resyncs.
//
// Ports
//   clk         in   1   rising-edge clock
//   rst         in   1   synchronous, active-high reset
//   char_in     in   8   ASCII character
//   char_valid  in   1   char_in is valid this cycle
//   char_ready  out  1   parser accepts char_in this cycle
//   bin_num     out  N   parsed word (first digit in bin_num[N-1:N-4])
//   bin_valid   out  1   bin_num holds a complete word
//   bin_ready   in   1   downstream consumes bin_num
//   err         out  1   one-cycle pulse: a non-hex character was accepted
// -----------------------------------------------------------------------------
module hex2binary_stream #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   char_in,
  input  logic         char_valid,
  output logic         char_ready,
  output logic [N-1:0] bin_num,
  output logic         bin_valid,
  input  logic         bin_ready,
  output logic         err
);

  localparam int DIGITS = N / 4;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  typedef enum logic {
    COLLECT,
    OUTPUT
  } state_t;

  // Returns {valid, nibble}. Letters of either case share the low five code
  // bits, so 'A'/'a' = x1 and adding 9 to the low nibble yields 10..15.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] res;
    res = 5'b0;
    if (c >= 8'h30 && c <= 8'h39)
      res = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      res = {1'b1, c[3:0] + 4'd9};
    return res;
  endfunction

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  // Only the first DIGITS-1 digits ever need to be kept; the last digit is
  // merged straight into bin_num on the accepting edge.
  logic [N-5:0]     acc, acc_nx;
  logic [N-1:0]     bin_num_nx;
  logic             bin_valid_nx;
  logic             err_nx;
  logic [4:0]       dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      cnt       <= '0;
      acc       <= '0;
      bin_num   <= '0;
      bin_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      acc       <= acc_nx;
      bin_num   <= bin_num_nx;
      bin_valid <= bin_valid_nx;
      err       <= err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    acc_nx       = acc;
    bin_num_nx   = bin_num;
    bin_valid_nx = bin_valid;
    err_nx       = 1'b0;
    char_ready   = 1'b0;
    dec          = hex_decode(char_in);

    case (state)
      COLLECT: begin
        char_ready = !rst;
        if (char_valid) begin
          if (dec[4]) begin
            if (cnt == LAST_DIGIT) begin
              bin_num_nx   = {acc, dec[3:0]};
              bin_valid_nx = 1'b1;
              cnt_nx       = '0;
              acc_nx       = '0;
              state_nx     = OUTPUT;
            end else begin
              acc_nx = (N-4)'({acc, dec[3:0]});
              cnt_nx = cnt + CNT_W'(1);
            end
          end else begin
            // Resync: drop the partial word and flag the bad character.
            err_nx = 1'b1;
            acc_nx = '0;
            cnt_nx = '0;
          end
        end
      end
      OUTPUT: begin
        if (bin_ready) begin
          bin_valid_nx = 1'b0;
          state_nx     = COLLECT;
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

endmodule
